// File: rtl/alu_result_stage_if.sv
// Bundles the ALU-side input packet, the write-back/branch output packet and
// their valid/ready handshakes into one port group for alu_result_stage.
interface alu_result_stage_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             over_flow;
  logic [4:0]       rd;
  logic             reg_write;
  logic             branch;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] br_target_in;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] wb_data;
  logic [4:0]       wb_rd;
  logic             wb_en;
  logic             br_taken;
  logic [WIDTH-1:0] br_target;
  logic [CNT_W-1:0] taken_cnt;

  // The stage itself.
  modport slave (
    input  flush, in_valid, result, zero, negative, carry, over_flow,
           rd, reg_write, branch, funct3, br_target_in, out_ready,
    output in_ready, out_valid, wb_data, wb_rd, wb_en, br_taken,
           br_target, taken_cnt
  );

  // The environment: ALU/source on the input side, write-back on the output side.
  modport master (
    output flush, in_valid, result, zero, negative, carry, over_flow,
           rd, reg_write, branch, funct3, br_target_in, out_ready,
    input  in_ready, out_valid, wb_data, wb_rd, wb_en, br_taken,
           br_target, taken_cnt
  );
endinterface

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: resolves the branch condition at capture and
// hands packets downstream through a two-entry (head + skid) FIFO.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  alu_result_stage_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [4:0]       rd;
    logic             wb_en;
    logic             br_taken;
    logic [WIDTH-1:0] target;
  } pkt_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Flag-based RISC-V branch conditions; carry means "no borrow" on a-b.
  function automatic logic branch_cond(input logic [2:0] f3,
                                       input logic z, input logic n,
                                       input logic c, input logic v);
    logic cond;
    case (f3)
      3'b000:  cond = z;
      3'b001:  cond = !z;
      3'b100:  cond = n ^ v;
      3'b101:  cond = !(n ^ v);
      3'b110:  cond = !c;
      3'b111:  cond = c;
      default: cond = 1'b0;
    endcase
    return cond;
  endfunction

  logic             h_valid_q, h_valid_d;
  logic             s_valid_q, s_valid_d;
  pkt_t             h_pkt_q,   h_pkt_d;
  pkt_t             s_pkt_q,   s_pkt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  pkt_t new_pkt;
  logic accept;
  logic hand_off;
  logic h_free;

  always_comb begin
    new_pkt          = '0;
    new_pkt.data     = bus.result;
    new_pkt.rd       = bus.rd;
    new_pkt.wb_en    = bus.reg_write && (bus.rd != 5'd0);
    new_pkt.br_taken = bus.branch &&
                       branch_cond(bus.funct3, bus.zero, bus.negative,
                                   bus.carry, bus.over_flow);
    new_pkt.target   = bus.br_target_in;
  end

  assign accept   = bus.in_valid && !s_valid_q;
  assign hand_off = h_valid_q && bus.out_ready;
  assign h_free   = !h_valid_q || hand_off;

  always_comb begin
    h_valid_d   = h_valid_q;
    s_valid_d   = s_valid_q;
    h_pkt_d     = h_pkt_q;
    s_pkt_d     = s_pkt_q;
    taken_cnt_d = taken_cnt_q;

    if (bus.flush) begin
      // Packet contents are left alone so the outputs keep their last value.
      h_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else begin
      if (h_free) begin
        if (s_valid_q) begin
          h_valid_d = 1'b1;
          h_pkt_d   = s_pkt_q;
          s_valid_d = accept;
          if (accept) begin
            s_pkt_d = new_pkt;
          end
        end else begin
          h_valid_d = accept;
          if (accept) begin
            h_pkt_d = new_pkt;
          end
        end
      end else if (accept) begin
        s_valid_d = 1'b1;
        s_pkt_d   = new_pkt;
      end

      if (hand_off && h_pkt_q.br_taken && (taken_cnt_q != CNT_MAX)) begin
        taken_cnt_d = taken_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_valid_q   <= 1'b0;
      s_valid_q   <= 1'b0;
      h_pkt_q     <= '0;
      s_pkt_q     <= '0;
      taken_cnt_q <= '0;
    end else begin
      h_valid_q   <= h_valid_d;
      s_valid_q   <= s_valid_d;
      h_pkt_q     <= h_pkt_d;
      s_pkt_q     <= s_pkt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign bus.in_ready  = !s_valid_q;
  assign bus.out_valid = h_valid_q;
  assign bus.wb_data   = h_pkt_q.data;
  assign bus.wb_rd     = h_pkt_q.rd;
  assign bus.wb_en     = h_pkt_q.wb_en;
  assign bus.br_taken  = h_pkt_q.br_taken;
  assign bus.br_target = h_pkt_q.target;
  assign bus.taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: a packet-queue reference model,
// a branch-decode vector table, hand-written corner sequences and random traffic.
module tb_alu_result_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_result_stage_if #(.WIDTH(32), .CNT_W(16)) bus ();
  alu_result_stage_if #(.WIDTH(32), .CNT_W(4))  bus4 ();

  alu_result_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  alu_result_stage #(.WIDTH(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave)
  );

  // The narrow-counter instance sees exactly the same traffic.
  assign bus4.flush        = bus.flush;
  assign bus4.in_valid     = bus.in_valid;
  assign bus4.result       = bus.result;
  assign bus4.zero         = bus.zero;
  assign bus4.negative     = bus.negative;
  assign bus4.carry        = bus.carry;
  assign bus4.over_flow    = bus.over_flow;
  assign bus4.rd           = bus.rd;
  assign bus4.reg_write    = bus.reg_write;
  assign bus4.branch       = bus.branch;
  assign bus4.funct3       = bus.funct3;
  assign bus4.br_target_in = bus.br_target_in;
  assign bus4.out_ready    = bus.out_ready;

  typedef struct {
    logic        in_valid;
    logic [31:0] result;
    logic        zero, negative, carry, over_flow;
    logic [4:0]  rd;
    logic        reg_write;
    logic        branch;
    logic [2:0]  funct3;
    logic [31:0] target;
    logic        out_ready;
    logic        flush;
    logic        exp_taken;
  } drv_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wb_en;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  typedef struct {
    logic [2:0] funct3;
    logic       zero, negative, carry, over_flow, branch;
    logic       exp_taken;
  } br_vec_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        q[$];
  int unsigned model_taken = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned sat(input int unsigned v, input int unsigned m);
    return (v > m) ? m : v;
  endfunction

  function automatic drv_t idle(input logic out_ready);
    drv_t d;
    d = '{in_valid: 1'b0, result: 32'd0, zero: 1'b0, negative: 1'b0,
          carry: 1'b0, over_flow: 1'b0, rd: 5'd0, reg_write: 1'b0,
          branch: 1'b0, funct3: 3'd0, target: 32'd0, out_ready: out_ready,
          flush: 1'b0, exp_taken: 1'b0};
    return d;
  endfunction

  // Builds a branch packet from real operands: flags come from a-b, and the
  // expected decision from plain equality/signed/unsigned comparisons.
  function automatic drv_t aluPacket(input logic [31:0] a, input logic [31:0] b,
                                     input logic [2:0] f3, input logic br);
    drv_t        d;
    logic [31:0] diff;
    logic        cond;
    diff        = a - b;
    d           = idle(1'b1);
    d.in_valid  = 1'b1;
    d.result    = diff;
    d.zero      = (diff == 32'd0);
    d.negative  = diff[31];
    d.carry     = (a >= b);
    d.over_flow = (a[31] != b[31]) && (diff[31] != a[31]);
    d.branch    = br;
    d.funct3    = f3;
    d.target    = a ^ 32'h0000_1000;
    case (f3)
      3'd0:    cond = (a == b);
      3'd1:    cond = (a != b);
      3'd4:    cond = ($signed(a) <  $signed(b));
      3'd5:    cond = ($signed(a) >= $signed(b));
      3'd6:    cond = (a < b);
      3'd7:    cond = (a >= b);
      default: cond = 1'b0;
    endcase
    d.exp_taken = br && cond;
    return d;
  endfunction

  task automatic checkOutput();
    cmp("out_valid", bus.out_valid, q.size() > 0);
    cmp("in_ready", bus.in_ready, q.size() < 2);
    if (q.size() > 0) begin
      cmp("wb_data", bus.wb_data, q[0].data);
      cmp("wb_rd", bus.wb_rd, q[0].rd);
      cmp("wb_en", bus.wb_en, q[0].wb_en);
      cmp("br_taken", bus.br_taken, q[0].taken);
      cmp("br_target", bus.br_target, q[0].target);
    end
    cmp("taken_cnt", bus.taken_cnt, sat(model_taken, 65535));
    cmp("taken_cnt4", bus4.taken_cnt, sat(model_taken, 15));
  endtask

  task automatic drive(input drv_t d);
    bus.in_valid     = d.in_valid;
    bus.result       = d.result;
    bus.zero         = d.zero;
    bus.negative     = d.negative;
    bus.carry        = d.carry;
    bus.over_flow    = d.over_flow;
    bus.rd           = d.rd;
    bus.reg_write    = d.reg_write;
    bus.branch       = d.branch;
    bus.funct3       = d.funct3;
    bus.br_target_in = d.target;
    bus.out_ready    = d.out_ready;
    bus.flush        = d.flush;
  endtask

  // Called at a falling edge; returns whether the model accepted the packet.
  task automatic applyStimulus(input drv_t d, output bit acc);
    int pre;
    bit hand;
    drive(d);
    @(posedge clk);
    pre  = q.size();
    acc  = d.in_valid && (pre < 2);
    hand = (pre > 0) && d.out_ready;
    if (d.flush) begin
      q.delete();
    end else begin
      if (hand) begin
        if (q[0].taken) model_taken++;
        void'(q.pop_front());
      end
      if (acc) begin
        q.push_back('{data: d.result, rd: d.rd,
                      wb_en: d.reg_write && (d.rd != 5'd0),
                      taken: d.exp_taken, target: d.target});
      end
    end
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idleCycles(input int n, input logic out_ready);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(idle(out_ready), acc);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    br_vec_t     vecs[8];
    drv_t        d;
    bit          acc;
    int          ntaken;
    int unsigned saved;

    vecs[0] = '{funct3: 3'b000, zero: 1, negative: 0, carry: 0, over_flow: 0, branch: 1, exp_taken: 1};
    vecs[1] = '{funct3: 3'b100, zero: 0, negative: 1, carry: 0, over_flow: 1, branch: 1, exp_taken: 0};
    vecs[2] = '{funct3: 3'b110, zero: 0, negative: 0, carry: 0, over_flow: 0, branch: 1, exp_taken: 1};
    vecs[3] = '{funct3: 3'b111, zero: 0, negative: 0, carry: 0, over_flow: 0, branch: 1, exp_taken: 0};
    vecs[4] = '{funct3: 3'b011, zero: 1, negative: 1, carry: 1, over_flow: 1, branch: 1, exp_taken: 0};
    vecs[5] = '{funct3: 3'b001, zero: 0, negative: 0, carry: 1, over_flow: 0, branch: 1, exp_taken: 1};
    vecs[6] = '{funct3: 3'b101, zero: 0, negative: 1, carry: 0, over_flow: 0, branch: 1, exp_taken: 0};
    vecs[7] = '{funct3: 3'b000, zero: 1, negative: 0, carry: 1, over_flow: 0, branch: 0, exp_taken: 0};

    rst_n = 1'b0;
    drive(idle(1'b0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("rst_out_valid", bus.out_valid, 0);
    cmp("rst_in_ready", bus.in_ready, 1);
    cmp("rst_wb_data", bus.wb_data, 0);
    cmp("rst_wb_rd", bus.wb_rd, 0);
    cmp("rst_wb_en", bus.wb_en, 0);
    cmp("rst_br_taken", bus.br_taken, 0);
    cmp("rst_br_target", bus.br_target, 0);
    cmp("rst_taken_cnt", bus.taken_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput();

    $display("[TB] streaming 8 packets");
    for (int i = 0; i < 8; i++) begin
      d           = idle(1'b1);
      d.in_valid  = 1'b1;
      d.result    = i;
      d.rd        = 5'(i);
      d.reg_write = 1'b1;
      d.target    = 32'(i * 4);
      applyStimulus(d, acc);
    end
    idleCycles(2, 1'b1);

    $display("[TB] branch decode table");
    ntaken = 0;
    for (int k = 0; k < 8; k++) begin
      d           = idle(1'b1);
      d.in_valid  = 1'b1;
      d.result    = 32'(100 + k);
      d.rd        = 5'(k + 1);
      d.reg_write = 1'b1;
      d.zero      = vecs[k].zero;
      d.negative  = vecs[k].negative;
      d.carry     = vecs[k].carry;
      d.over_flow = vecs[k].over_flow;
      d.branch    = vecs[k].branch;
      d.funct3    = vecs[k].funct3;
      d.target    = 32'h8000_0000 + 32'(k);
      d.exp_taken = vecs[k].exp_taken;
      if (vecs[k].exp_taken) ntaken++;
      applyStimulus(d, acc);
    end
    idleCycles(2, 1'b1);
    cmp("table_taken_cnt", bus.taken_cnt, ntaken);

    $display("[TB] back-pressure A B C");
    for (int k = 0; k < 3; k++) begin
      d           = idle(1'b0);
      d.in_valid  = 1'b1;
      d.result    = 32'hA0 + 32'(k);
      d.rd        = 5'(10 + k);
      d.reg_write = 1'b1;
      applyStimulus(d, acc);
    end
    cmp("bp_c_refused", acc, 0);
    cmp("bp_in_ready_low", bus.in_ready, 0);
    d.out_ready = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 8 && !acc; t++) applyStimulus(d, acc);
    cmp("bp_c_accepted", acc, 1);
    idleCycles(4, 1'b1);

    $display("[TB] flush with both entries full");
    for (int k = 0; k < 2; k++) begin
      d        = aluPacket(32'h55, 32'h55, 3'b000, 1'b1);
      d.rd     = 5'(20 + k);
      d.out_ready = 1'b0;
      applyStimulus(d, acc);
    end
    saved       = model_taken;
    d           = aluPacket(32'hDEAD, 32'hDEAD, 3'b000, 1'b1);
    d.flush     = 1'b1;
    d.out_ready = 1'b1;
    applyStimulus(d, acc);
    cmp("flush_out_valid", bus.out_valid, 0);
    cmp("flush_in_ready", bus.in_ready, 1);
    cmp("flush_taken_cnt", bus.taken_cnt, saved);
    idleCycles(3, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a + $urandom_range(0, 3) - 32'd1;
        default: b = $urandom;
      endcase
      d           = aluPacket(a, b, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      d.in_valid  = ($urandom_range(0, 3) != 0);
      d.rd        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      d.reg_write = 1'($urandom);
      d.out_ready = ($urandom_range(0, 9) < 7);
      d.flush     = ($urandom_range(0, 49) == 0);
      applyStimulus(d, acc);
    end
    idleCycles(3, 1'b1);
    if (model_taken >= 20) cmp("sat4_taken_cnt", bus4.taken_cnt, 15);
    else cmp("sat4_enough_branches", model_taken, 20);

    $display("[TB] asynchronous reset mid-stream");
    for (int k = 0; k < 2; k++) begin
      d           = idle(1'b0);
      d.in_valid  = 1'b1;
      d.result    = 32'hC0 + 32'(k);
      d.rd        = 5'(k + 3);
      d.reg_write = 1'b1;
      applyStimulus(d, acc);
    end
    #1 rst_n = 1'b0;
    #1;
    cmp("arst_out_valid", bus.out_valid, 0);
    cmp("arst_in_ready", bus.in_ready, 1);
    cmp("arst_taken_cnt", bus.taken_cnt, 0);
    cmp("arst_wb_data", bus.wb_data, 0);
    q.delete();
    model_taken = 0;
    drive(idle(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput();
    for (int k = 0; k < 3; k++) begin
      d           = idle(1'b1);
      d.in_valid  = 1'b1;
      d.result    = 32'hE0 + 32'(k);
      d.rd        = 5'(k);
      d.reg_write = 1'b1;
      applyStimulus(d, acc);
    end
    idleCycles(2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
